// File: rtl/washmach_pkg.sv
// Shared washing-machine definitions: FSM state encoding, phase bit indices,
// the empty-mode mask and phase sequencing helpers.
package washmach_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WASH  = 3'd1,
    ST_RINSE = 3'd2,
    ST_DRY   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int PH_WASH  = 0;
  localparam int PH_RINSE = 1;
  localparam int PH_DRY   = 2;

  localparam logic [2:0] MODE_NONE = 3'b000;

  function automatic logic [2:0] phase_onehot(input state_t s);
    logic [2:0] v;
    v = 3'b000;
    case (s)
      ST_WASH:  v[PH_WASH]  = 1'b1;
      ST_RINSE: v[PH_RINSE] = 1'b1;
      ST_DRY:   v[PH_DRY]   = 1'b1;
      default:  v = 3'b000;
    endcase
    return v;
  endfunction

  // From ST_IDLE this yields the first enabled phase; ST_DONE when none remain.
  function automatic state_t next_phase(input state_t s, input logic [2:0] m);
    state_t n;
    n = ST_DONE;
    case (s)
      ST_IDLE: begin
        if (m[PH_WASH])       n = ST_WASH;
        else if (m[PH_RINSE]) n = ST_RINSE;
        else if (m[PH_DRY])   n = ST_DRY;
      end
      ST_WASH: begin
        if (m[PH_RINSE])      n = ST_RINSE;
        else if (m[PH_DRY])   n = ST_DRY;
      end
      ST_RINSE: begin
        if (m[PH_DRY])        n = ST_DRY;
      end
      default: n = ST_DONE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wash_phase_seq_phase_timer.sv
// Loadable phase down-counter stepped by the 1 Hz tick; flags the tick that
// takes it from 1 to 0, both combinationally and one cycle later as a register.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  input  logic             i_hold,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_expiring,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expired;
  logic             w_step;

  assign w_step     = i_tick & ~i_hold & (r_cnt != '0);
  assign o_expiring = w_step & (r_cnt == CNT_W'(1));
  assign o_cnt      = r_cnt;
  assign o_expired  = r_expired;

  // A load on the expiring edge replaces the zero with the next phase length.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= o_expiring;
      if (i_load)      r_cnt <= i_load_val;
      else if (w_step) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/wash_phase_seq.sv
// Washing-cycle sequencer: runs enabled wash/rinse/dry phases timed by tick.
// Define WASHMACH_AUTO_OFF_EN to request power-off AUTO_OFF_T ticks into DONE.
module wash_phase_seq
  import washmach_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int WASH_T     = 3,
  parameter int RINSE_T    = 2,
  parameter int DRY_T      = 4,
  parameter int AUTO_OFF_T = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power,
  input  logic             tick,
  input  logic             start_pause,
  input  logic [2:0]       mode,
  input  logic [2:0]       weight,
  output logic [2:0]       w_r_d_end,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remain,
  output logic             running,
  output logic             done,
  output logic             auto_off,
  output logic [2:0]       dbg_state
);

`ifdef WASHMACH_AUTO_OFF_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  localparam int OFF_W = $clog2(AUTO_OFF_T + 1);

  state_t           r_state, w_next, r_held;
  logic [2:0]       r_mode, r_wt, w_wt_in, r_end_ph;
  logic [OFF_W-1:0] r_off_cnt;
  logic             r_auto_off, w_auto_off_now;
  logic             w_clr, w_in_phase, w_hold, w_load;
  logic             w_expiring, w_expired;
  logic [CNT_W-1:0] w_load_val, w_cnt;

  function automatic logic [CNT_W-1:0] dur(input state_t s, input logic [2:0] wt);
    logic [CNT_W-1:0] t;
    case (s)
      ST_WASH:  t = CNT_W'(WASH_T);
      ST_RINSE: t = CNT_W'(RINSE_T);
      ST_DRY:   t = CNT_W'(DRY_T);
      default:  t = '0;
    endcase
    return CNT_W'(wt) * t;
  endfunction

  assign w_clr      = rst | ~power;
  assign w_wt_in    = (weight == 3'd0) ? 3'd1 : weight;
  assign w_in_phase = (r_state == ST_WASH) || (r_state == ST_RINSE) || (r_state == ST_DRY);
  // A button press in the same cycle as a tick pauses and swallows that tick.
  assign w_hold     = ~w_in_phase | start_pause;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (clk),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (tick),
    .i_hold     (w_hold),
    .o_cnt      (w_cnt),
    .o_expiring (w_expiring),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mode     <= 3'b000;
      r_wt       <= 3'b000;
      r_held     <= ST_IDLE;
      r_end_ph   <= 3'b000;
      r_auto_off <= 1'b0;
      r_off_cnt  <= '0;
    end else begin
      if (r_state == ST_IDLE && start_pause && mode != MODE_NONE) begin
        r_mode <= mode;
        r_wt   <= w_wt_in;
      end
      if (w_in_phase && start_pause) r_held <= r_state;
      if (w_expiring) r_end_ph <= phase_onehot(r_state);
      r_auto_off <= w_auto_off_now;
      if (r_state != ST_DONE) r_off_cnt <= '0;
      else if (tick)          r_off_cnt <= r_off_cnt + OFF_W'(1);
    end
  end

  always_comb begin
    w_next         = r_state;
    w_load         = 1'b0;
    w_load_val     = '0;
    w_auto_off_now = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_pause && mode != MODE_NONE) begin
          w_next     = next_phase(ST_IDLE, mode);
          w_load     = 1'b1;
          w_load_val = dur(w_next, w_wt_in);
        end
      end
      ST_WASH, ST_RINSE, ST_DRY: begin
        if (start_pause) begin
          w_next = ST_PAUSE;
        end else if (w_expiring) begin
          w_next     = next_phase(r_state, r_mode);
          w_load     = 1'b1;
          w_load_val = dur(w_next, r_wt);
        end
      end
      ST_PAUSE: begin
        if (start_pause) w_next = r_held;
      end
      ST_DONE: begin
        if (start_pause) begin
          w_next = ST_IDLE;
        end else if (AUTO_EN && tick && r_off_cnt == OFF_W'(AUTO_OFF_T - 1)) begin
          w_next         = ST_IDLE;
          w_auto_off_now = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    phase   = phase_onehot(r_state);
    remain  = w_cnt;
    running = w_in_phase;
    done    = (r_state == ST_DONE);
    if (r_state == ST_PAUSE) phase = phase_onehot(r_held);
    if (!(w_in_phase || r_state == ST_PAUSE)) remain = '0;
  end

  assign w_r_d_end = w_expired ? r_end_ph : 3'b000;
  assign auto_off  = r_auto_off;
  assign dbg_state = r_state;

endmodule

// File: doc/wash_phase_seq.md
Name: wash_phase_seq

Overview:
- Washing-cycle sequencer: runs the enabled wash / rinse / dry phases in order, timing each from a 1 Hz tick.
- It is the producer of the per-phase end pulses (w_r_d_end) and the running status consumed by the alarm ring and the display.
- Sits between the button/mode logic (start, mode mask, weight) and the alarm/display blocks.
- Mode and weight are latched at start; changes during a run are ignored.

Parameters:
- CNT_W, 8: width of the phase down-counter and of remain.
- WASH_T, 3: wash seconds per weight unit.
- RINSE_T, 2: rinse seconds per weight unit.
- DRY_T, 4: dry seconds per weight unit.
- AUTO_OFF_T, 10: ticks spent in DONE before auto_off fires (optional feature only).

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- power  in  1  machine power; low acts as synchronous clear, same effect as rst
- tick  in  1  one-cycle 1 Hz strobe from the clock divider
- start_pause  in  1  one-cycle debounced button pulse
- mode  in  3  phase enable mask: bit0 wash, bit1 rinse, bit2 dry
- weight  in  3  load weight; 0 is treated as 1
- w_r_d_end  out  3  one-cycle pulse on phase end; bit0 wash, bit1 rinse, bit2 dry
- phase  out  3  one-hot active phase, same bit order; 000 when not in a phase
- remain  out  CNT_W  seconds left in the current phase
- running  out  1  high in WASH, RINSE or DRY
- done  out  1  high in DONE
- auto_off  out  1  one-cycle power-off request

Behaviour:
- Reset (rst=1 or power=0 at a clock edge): state IDLE. All outputs 0. Latched mode/weight cleared.
- States: IDLE, WASH, RINSE, DRY, PAUSE, DONE.
- IDLE + start_pause:
  - If mode==000, the pulse is ignored.
  - Otherwise latch mode and clamped weight, enter the lowest enabled phase, and load its duration weight*T.
- Duration arithmetic: product computed at CNT_W bits. Legal parameter set guarantees 7*T <= 2^CNT_W-1; no saturation logic.
- In a phase, each tick decrements the counter.
- On the edge where tick=1 and counter==1:
  - counter reaches 0;
  - that edge sets the matching w_r_d_end bit, high exactly one cycle;
  - the same edge moves to the next enabled phase and loads its duration;
  - if no phase remains, the state becomes DONE.
- Only one w_r_d_end bit is ever high at a time.
- Running phase + start_pause: enter PAUSE, holding counter and phase.
  - If tick and start_pause arrive in the same cycle, the pause wins and the tick is discarded.
- PAUSE:
  - Ticks are ignored; phase output still shows the held phase; running=0.
  - start_pause resumes the held phase with the counter unchanged.
- DONE:
  - done=1; start_pause returns to IDLE without starting a run.
  - Otherwise DONE holds; see Optional Feature.
- remain: current counter in a phase or PAUSE; 0 in IDLE/DONE.
- Latency: all outputs are registered; they reflect the state after the edge. No combinational input-to-output paths.
- Reset mid-run: immediate IDLE. Any w_r_d_end pulse in flight is dropped.

Optional Feature:
- Macro: WASHMACH_AUTO_OFF_EN.
- Defined:
  - DONE counts ticks.
  - On the AUTO_OFF_T-th tick, auto_off pulses for one cycle and the state returns to IDLE.
  - start_pause before that tick returns to IDLE with no auto_off.
- Undefined: auto_off tied 0; DONE holds indefinitely.

Decomposition:
- Shared package washmach_pkg holds:
  - state encoding constants;
  - phase bit indices (PH_WASH=0, PH_RINSE=1, PH_DRY=2);
  - the MODE_NONE mask constant.
- One natural sub-module, phase_timer, containing:
  - CNT_W loadable down-counter with tick enable and hold input;
  - a registered "expiring" flag (counter==1 and tick).
- The FSM and the w_r_d_end/phase encoding stay in wash_phase_seq.

Test Plan:
- mode=111, weight=2, default T, continuous 1 Hz ticks, start pulse:
  - w_r_d_end=001 after 6 ticks, then 010 after 4 more, then 100 after 8 more;
  - each pulse is 1 cycle;
  - done=1 afterwards.
- mode=101, weight=0, start: wash of 3 ticks (weight clamped to 1), then dry of 4 ticks; no rinse pulse; phase goes 001 -> 100.
- Pause during wash with remain=4:
  - 5 ticks while paused leave remain=4 and produce no w_r_d_end;
  - resume finishes wash after 4 ticks.
- tick and start_pause in the same cycle with remain=1 -> PAUSE with remain=1 and no w_r_d_end; resume plus 1 tick -> w_r_d_end=001.
- power dropped mid-rinse -> next edge: phase=000, running=0, remain=0; mode=000 plus start in IDLE -> stays IDLE.
- With WASHMACH_AUTO_OFF_EN and AUTO_OFF_T=10: reaching DONE then 10 ticks -> auto_off pulses once and the state is IDLE. Without the macro, auto_off stays 0 for 20 ticks and done stays 1.
